// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell (a - b - borrow_in), gate-level like the adder cells.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    wire a_n;
    wire t_ab;
    wire t_abor;
    wire t_bbor;

    not u_inv  (a_n, a);
    xor u_diff (diff, a, b, borrow_in);
    and u_and0 (t_ab, a_n, b);
    and u_and1 (t_abor, a_n, borrow_in);
    and u_and2 (t_bbor, b, borrow_in);
    or  u_bor  (borrow_out, t_ab, t_abor, t_bbor);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first,
// with a start/busy/done handshake. Vectors use [0:WIDTH-1] with index 0 = LSB.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] diff,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [0:WIDTH-1] a_sr;
    logic [0:WIDTH-1] b_sr;
    logic [0:WIDTH-1] res_sr;
    logic             bor;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bor;

    full_subtractor_bit u_cell (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .borrow_in (bor),
        .diff      (cell_d),
        .borrow_out(cell_bor)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start directly so back-to-back ops skip IDLE
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bor   <= borrow_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= {a_sr[1:WIDTH-1], 1'b0};
                    b_sr   <= {b_sr[1:WIDTH-1], 1'b0};
                    res_sr <= {res_sr[1:WIDTH-1], cell_d};
                    bor    <= cell_bor;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= {res_sr[1:WIDTH-1], cell_d};
                        borrow_out <= cell_bor;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor: computes diff = a - b - borrow_in one bit per clock, LSB first.
It is the inverse-direction companion to the team's combinational ripple adder. It uses a single full-subtractor cell plus a borrow flip-flop in place of a WIDTH-deep ripple chain.
Start/busy/done handshake for datapaths that trade latency for area.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  [0:WIDTH-1]  minuend; bit 0 = LSB
b  input  [0:WIDTH-1]  subtrahend; bit 0 = LSB
borrow_in  input  1  borrow into bit 0
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: result valid
diff  output  [0:WIDTH-1]  result; bit 0 = LSB; held until the next done
borrow_out  output  1  borrow out of bit WIDTH-1 (1 = a < b + borrow_in, unsigned)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift regs, borrow FF and counter cleared. Applies mid-operation; in-flight op is discarded and no done is issued.
- Bit convention: index 0 is LSB on all vectors.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE: start=1 at edge -> latch a, b into shift regs and borrow_in into borrow FF; cnt=0; go to RUN.
- RUN, each edge:
  - Cell computes d = a0 ^ b0 ^ bor and bor' = (~a0 & b0) | (~a0 & bor) | (b0 & bor).
  - d shifts into the result shift reg at the MSB end; a and b shift toward LSB; bor <= bor'; cnt++.
  - When cnt reaches WIDTH-1, on that edge: go to DONE; diff <= completed result; borrow_out <= bor'.
- DONE: done=1. Next edge: if start=1, latch new operands and go to RUN (back-to-back accepted); else go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH. Throughput: one op per WIDTH+1 cycles.
- start while busy=1: ignored; operands not re-sampled; no error flag.
- a, b, borrow_in may change freely after the accepting edge.
- diff and borrow_out change only at the edge that raises done. Otherwise stable, including across IDLE.
- Arithmetic: modulo 2^WIDTH; unsigned borrow semantics. No signed overflow output.

Decomposition:
- Shared package/include: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
- One sub-module: full_subtractor_bit (inputs a, b, borrow_in; outputs diff, borrow_out), purely combinational, built from gate primitives like the existing adder cells.
- FSM, counter and shift registers live in the top.

Test Plan:
- Reset, then a=9, b=3, borrow_in=0, start pulse -> busy for 4 cycles; done in cycle 5 after start; diff=6, borrow_out=0.
- a=3, b=9, borrow_in=0 -> diff=10, borrow_out=1.
- a=0, b=0, borrow_in=1 -> diff=15, borrow_out=1.
- a=15, b=15, borrow_in=1 -> diff=15, borrow_out=1.
- Busy-cycle start is ignored: start a=7, b=2; during RUN pulse start with a=1, b=1 -> exactly one done; diff=5.
- Back-to-back op: hold start=1 with a=8, b=1 through the DONE cycle of a prior op -> second op accepted without passing through IDLE; second done 5 cycles later; diff=7.
- Reset mid-op: assert rst_n=0 at cycle 2 of RUN -> busy=0, diff=0, borrow_out=0, no done. A new op afterwards gives the correct result.
